// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer: turns a single-cycle core's memory request into a
// req/gnt + rvalid bus transaction, stalling the core until it completes.
module lsu_mem_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  RW_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  FC_NONE     = 2'b00;
  localparam logic [1:0]  FC_MISALIGN = 2'b01;
  localparam logic [1:0]  FC_WIDTH    = 2'b10;
  localparam logic [1:0]  FC_TIMEOUT  = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  rw_q, rw_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  fc_q, fc_d;
  logic        req_in, timeout_hit;

  function automatic logic width_legal(input logic is_load, input logic [2:0] rw);
    case (rw)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return is_load;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] rw, input logic [1:0] off);
    return ((rw[1:0] == 2'b01) && off[0]) || ((rw[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] rw, input logic [1:0] off);
    case (rw[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] rw, input logic [31:0] d);
    case (rw[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend per access type.
  function automatic logic [31:0] load_extract(input logic [2:0] rw, input logic [1:0] off,
                                               input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {off, 3'b000};
    case (rw)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return d;
    endcase
  endfunction

  assign req_in      = MemRead | MemWrite;
  assign timeout_hit = (cnt_q >= TO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    fc_d    = fc_q;
    case (state_q)
      IDLE: begin
        if (req_in) begin
          if (!width_legal(MemRead, RW_type)) begin
            state_d = DONE;
            fc_d    = FC_WIDTH;
          end else if (misaligned(RW_type, addr[1:0])) begin
            state_d = DONE;
            fc_d    = FC_MISALIGN;
          end else begin
            state_d = REQ;
            cnt_d   = 16'd0;
            we_d    = ~MemRead;
            addr_d  = {addr[31:2], 2'b00};
            be_d    = byte_en(RW_type, addr[1:0]);
            wdata_d = lane_wdata(RW_type, wdata);
            rw_d    = RW_type;
            off_d   = addr[1:0];
          end
        end
      end
      REQ: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        // A grant on the deadline cycle still wins over the timeout.
        if (bus_gnt) begin
          state_d = we_q ? DONE : WAIT_R;
          if (we_q) fc_d = FC_NONE;
        end else if (timeout_hit) begin
          state_d = DONE;
          fc_d    = FC_TIMEOUT;
        end
      end
      WAIT_R: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (bus_rvalid) begin
          state_d = DONE;
          rdata_d = load_extract(rw_q, off_q, bus_rdata);
          fc_d    = FC_NONE;
        end else if (timeout_hit) begin
          state_d = DONE;
          fc_d    = FC_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rw_q    <= 3'd0;
      off_q   <= 2'd0;
      rdata_q <= 32'd0;
      fc_q    <= FC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      fc_q    <= fc_d;
    end
  end

  // DONE drops stall so the core commits the instruction exactly once.
  assign stall      = ((state_q == IDLE) && req_in) || (state_q == REQ) || (state_q == WAIT_R);
  assign done       = (state_q == DONE);
  assign fault      = done && (fc_q != FC_NONE);
  assign fault_code = fc_q;
  assign rdata      = rdata_q;
  assign bus_req    = (state_q == REQ);
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Scoreboard bench for lsu_mem_sequencer: stimulus pushes expected bus and
// completion records, a negedge monitor pops and compares them.
module tb_lsu_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [2:0]  RW_type;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic [1:0]  fault_code;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  lsu_mem_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .RW_type(RW_type), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata(rdata), .fault(fault), .fault_code(fault_code), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  code;
    string       name;
  } done_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    string       name;
  } bus_exp_t;

  done_exp_t   done_q[$];
  bus_exp_t    bus_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] rdata_model = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    done_exp_t de;
    bus_exp_t  bx;
    if (rst === 1'b0 && bus_req === 1'b1) begin
      if (bus_q.size() == 0) begin
        check("unexpected bus_req", 32'(bus_req), 32'd0);
      end else begin
        bx = bus_q[0];
        check({bx.name, " bus_we"}, 32'(bus_we), 32'(bx.we));
        check({bx.name, " bus_addr"}, bus_addr, bx.addr);
        check({bx.name, " bus_be"}, 32'(bus_be), 32'(bx.be));
        if (bx.we) check({bx.name, " bus_wdata"}, bus_wdata, bx.wdata);
        if (bus_gnt === 1'b1) void'(bus_q.pop_front());
      end
    end
    if (rst === 1'b0 && done === 1'b1) begin
      if (done_q.size() == 0) begin
        check("unexpected done", 32'(done), 32'd0);
      end else begin
        de = done_q.pop_front();
        check({de.name, " fault_code"}, 32'(fault_code), 32'(de.code));
        check({de.name, " fault"}, 32'(fault), 32'(de.code != 2'b00));
        check({de.name, " rdata"}, rdata, de.rdata);
      end
    end
  end

  // Caller enters at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  task automatic access(input string name, input bit ld, input logic [2:0] rw,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int gnt_wait, input int rv_wait, input logic [31:0] rd,
                        input logic [1:0] exp_code, input logic [31:0] exp_rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input int exp_lat, input int exp_reqs);
    int   lat, reqc, rvc;
    bit   granted, stall_ok;
    done_exp_t de;
    bus_exp_t  bx;
    lat = -1; reqc = 0; rvc = 0; granted = 0;
    if (ld && exp_code == 2'b00) rdata_model = exp_rd;
    de.rdata = rdata_model; de.code = exp_code; de.name = name;
    done_q.push_back(de);
    if (exp_code == 2'b00 || exp_code == 2'b11) begin
      bx.we = ~ld; bx.addr = {a[31:2], 2'b00}; bx.be = exp_be; bx.wdata = exp_wd; bx.name = name;
      bus_q.push_back(bx);
    end
    MemRead = ld; MemWrite = ~ld; RW_type = rw; addr = a; wdata = wd;
    #1;
    stall_ok = (stall === 1'b1);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (bus_req === 1'b1) reqc++;
      if (done === 1'b1) begin
        stall_ok = stall_ok && (stall === 1'b0);
        MemRead = 1'b0; MemWrite = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        if (exp_code == 2'b11) bus_q.delete();
        lat = cyc;
        break;
      end
      stall_ok = stall_ok && (stall === 1'b1);
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (granted && ld) begin
        if (rvc == rv_wait) begin
          bus_rvalid = 1'b1; bus_rdata = rd;
        end
        rvc++;
      end
      if (bus_req === 1'b1 && gnt_wait >= 0 && reqc == gnt_wait + 1) begin
        bus_gnt = 1'b1; granted = 1;
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " stall"}, 32'(stall_ok), 32'd1);
    if (exp_reqs >= 0) check({name, " bus_req cycles"}, 32'(reqc), 32'(exp_reqs));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; RW_type = 3'd0; addr = 32'd0; wdata = 32'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset stall", 32'(stall), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset fault", 32'(fault), 32'd0);
    check("reset fault_code", 32'(fault_code), 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset bus_req", 32'(bus_req), 32'd0);
    check("reset bus_we", 32'(bus_we), 32'd0);
    check("reset bus_addr", bus_addr, 32'd0);
    check("reset bus_be", 32'(bus_be), 32'd0);
    check("reset bus_wdata", bus_wdata, 32'd0);
    @(posedge clk); #1;

    //     name       ld rw      addr          wdata         gw rw rdata          code   exp_rd         be       wdata          lat reqs
    access("sw",      0, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 2, 0, 32'h0,         2'b00, 32'h0,         4'b1111, 32'hDEAD_BEEF, 4, 3);
    access("sb",      0, 3'b000, 32'h0000_0203, 32'h0000_00A5, 0, 0, 32'h0,         2'b00, 32'h0,         4'b1000, 32'hA5A5_A5A5, 2, 1);
    access("sh",      0, 3'b001, 32'h0000_0202, 32'h0000_1234, 0, 0, 32'h0,         2'b00, 32'h0,         4'b1100, 32'h1234_1234, 2, 1);
    access("lb",      1, 3'b000, 32'h0000_0301, 32'h0,         0, 0, 32'h0000_F000, 2'b00, 32'hFFFF_FFF0, 4'b0010, 32'h0,         3, 1);
    access("lbu",     1, 3'b100, 32'h0000_0301, 32'h0,         0, 0, 32'h0000_F000, 2'b00, 32'h0000_00F0, 4'b0010, 32'h0,         3, 1);
    access("lhu",     1, 3'b101, 32'h0000_0302, 32'h0,         0, 0, 32'h8000_0000, 2'b00, 32'h0000_8000, 4'b1100, 32'h0,         3, 1);
    access("lh",      1, 3'b001, 32'h0000_0302, 32'h0,         0, 0, 32'h8000_0000, 2'b00, 32'hFFFF_8000, 4'b1100, 32'h0,         3, 1);
    access("lw late", 1, 3'b010, 32'h0000_0100, 32'h0,         1, 1, 32'h1234_5678, 2'b00, 32'h1234_5678, 4'b1111, 32'h0,         5, 2);
    access("sw gnt@last", 0, 3'b010, 32'h0000_0108, 32'hCAFE_F00D, 3, 0, 32'h0,     2'b00, 32'h0,         4'b1111, 32'hCAFE_F00D, 5, 4);
    access("lw misal",1, 3'b010, 32'h0000_0102, 32'h0,         0, 0, 32'h0,         2'b01, 32'h0,         4'b0000, 32'h0,         1, 0);
    access("sh misal",0, 3'b001, 32'h0000_0201, 32'h0000_5555, 0, 0, 32'h0,         2'b01, 32'h0,         4'b0000, 32'h0,         1, 0);
    access("st w100", 0, 3'b100, 32'h0000_0200, 32'h0000_1111, 0, 0, 32'h0,         2'b10, 32'h0,         4'b0000, 32'h0,         1, 0);
    access("ld w011", 1, 3'b011, 32'h0000_0200, 32'h0,         0, 0, 32'h0,         2'b10, 32'h0,         4'b0000, 32'h0,         1, 0);
    access("lw tmo",  1, 3'b010, 32'h0000_0400, 32'h0,        -1, 0, 32'h0,         2'b11, 32'h0,         4'b1111, 32'h0,         5, 4);

    check("fault_code hold", 32'(fault_code), 32'd3);
    check("fault idle", 32'(fault), 32'd0);
    bus_rvalid = 1'b1; bus_gnt = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    repeat (3) @(posedge clk);
    #1;
    bus_rvalid = 1'b0; bus_gnt = 1'b0;
    check("late rvalid rdata", rdata, rdata_model);
    check("late rvalid done", 32'(done), 32'd0);

    begin
      bus_exp_t bx;
      bx.we = 1'b0; bx.addr = 32'h0000_0500; bx.be = 4'b1111; bx.wdata = 32'h0; bx.name = "lw rst";
      bus_q.push_back(bx);
    end
    MemRead = 1'b1; RW_type = 3'b010; addr = 32'h0000_0500;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    check("wait_r stall", 32'(stall), 32'd1);
    rst = 1'b1; MemRead = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rdata_model = 32'd0;
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst rdata", rdata, rdata_model);
    bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
    repeat (2) @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    check("post-rst rvalid rdata", rdata, rdata_model);
    check("post-rst rvalid done", 32'(done), 32'd0);
    check("scoreboard drained", 32'(done_q.size() + bus_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
